// File: rtl/cpu_sequencer.sv
// Run-control and 8-phase timing sequencer for the 8-bit accumulator CPU.
// Strobes are decoded from the registered run state, the phase and the IR opcode.
module cpu_sequencer #(
    parameter bit AUTO_RUN    = 1'b0,
    parameter bit STOP_ON_HLT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic       isZero,
    input  logic       start,
    input  logic       stop,
    input  logic       step,
    output logic       sel,
    output logic       rd,
    output logic       wr,
    output logic       ld_ir,
    output logic       ld_ac,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       data_e,
    output logic       halt,
    output logic [2:0] phase,
    output logic       busy,
    output logic       instr_done
);

    typedef enum logic [1:0] {HALTED, RUN, STEP} run_state_t;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    run_state_t state, state_next;
    logic [2:0] phase_q, phase_next;
    logic       aluop;
    logic       hlt_stop;
    logic       running;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= AUTO_RUN ? RUN : HALTED;
            phase_q <= 3'd0;
        end else begin
            state   <= state_next;
            phase_q <= phase_next;
        end
    end

    // Run-control moves only at instruction boundaries; an executing HLT cuts the cycle short.
    always_comb begin
        state_next = state;
        phase_next = phase_q;
        sel        = 1'b0;
        rd         = 1'b0;
        wr         = 1'b0;
        ld_ir      = 1'b0;
        ld_ac      = 1'b0;
        inc_pc     = 1'b0;
        ld_pc      = 1'b0;
        data_e     = 1'b0;
        halt       = 1'b0;
        instr_done = 1'b0;
        phase      = 3'd0;
        busy       = 1'b0;
        aluop      = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);
        hlt_stop   = STOP_ON_HLT && (opcode == OP_HLT);
        running    = (state != HALTED);

        if (!running) begin
            phase_next = 3'd0;
            if (!stop) begin
                if (step) begin
                    state_next = STEP;
                end else if (start) begin
                    state_next = RUN;
                end
            end
        end else if ((phase_q == 3'd4) && hlt_stop) begin
            state_next = HALTED;
            phase_next = 3'd0;
        end else if (phase_q == 3'd7) begin
            phase_next = 3'd0;
            if ((state == STEP) || stop) begin
                state_next = HALTED;
            end
        end else begin
            phase_next = phase_q + 3'd1;
        end

        // Outputs read as zero throughout a reset cycle so nothing half-done reaches memory.
        if (!rst && running) begin
            busy  = 1'b1;
            phase = phase_q;
            case (phase_q)
                3'd0: sel = 1'b1;
                3'd1: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                3'd2, 3'd3: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                3'd4: begin
                    inc_pc = 1'b1;
                    halt   = hlt_stop;
                end
                3'd5: rd = aluop;
                3'd6: begin
                    rd     = aluop;
                    inc_pc = (opcode == OP_SKZ) && isZero;
                    ld_pc  = (opcode == OP_JMP);
                    data_e = (opcode == OP_STO);
                end
                3'd7: begin
                    rd         = aluop;
                    ld_ac      = aluop;
                    ld_pc      = (opcode == OP_JMP);
                    wr         = (opcode == OP_STO);
                    data_e     = (opcode == OP_STO);
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
